// File: rtl/ssd_pkg.sv
// Shared 7-segment definitions.
// Holds the segment bit positions, the hex-to-segment table and a decode helper.
// The display encoder and the scan decoder both use this table, so the two ends
// always agree on what each glyph looks like.
// Segment vectors are active-high and ordered {g,f,e,d,c,b,a}.

package ssd_pkg;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    localparam int unsigned SEG_W = SEG_G + 1;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    // Entry i is the glyph for hex value i. Element 0 is the rightmost item.
    localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef struct packed {
        logic       valid;   // pattern is one of the 16 hex glyphs
        logic       blank;   // all segments off
        logic [3:0] value;   // decoded hex value, meaningful only when valid
    } seg_dec_t;

    // Encode a hex value as a segment pattern.
    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] value);
        return HEX_SEG[value];
    endfunction

    // Decode a segment pattern. Blank and unrecognised patterns both return
    // valid = 0; blank separates the two cases.
    function automatic seg_dec_t seg_decode(input logic [SEG_W-1:0] seg);
        seg_dec_t dec;
        dec = '0;
        for (int i = 0; i < 16; i++) begin
            if (seg == HEX_SEG[i]) begin
                dec.valid = 1'b1;
                dec.value = 4'(i);
            end
        end
        dec.blank = (seg == SEG_BLANK);
        return dec;
    endfunction

endpackage

// File: rtl/ssd_settle_filter.sv
// Input stage and settle filter for a multiplexed 7-segment bus.
// Registers the pins once and normalises them to active-high. It then counts
// how many consecutive samples have held the same (dig, ssd) pair, and strobes
// capture on the one cycle the count reaches SETTLE_CYCLES. A stable pattern
// is therefore captured SETTLE_CYCLES+1 edges after it first appears at the
// pins.
//
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   ssd, dig    raw segment bus and digit selects from the pins
//   seg_cap     normalised segments of the registered sample
//   dig_cap     normalised selects of the registered sample (one-hot when capture)
//   capture     one-cycle strobe: seg_cap/dig_cap have just settled
//   glitch      more than one select active in the registered sample

module ssd_settle_filter
    import ssd_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,     // legal range 2..255
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEG_W-1:0] ssd,
    input  logic [3:0]       dig,
    output logic [SEG_W-1:0] seg_cap,
    output logic [3:0]       dig_cap,
    output logic             capture,
    output logic             glitch
);

    localparam logic [7:0] SettleMax = 8'(SETTLE_CYCLES);

    // The input registers hold already-normalised values. Clearing them to 0
    // therefore means "idle bus", so a reset never produces a spurious glitch.
    logic [SEG_W-1:0] seg_q, seg_prev_q;
    logic [3:0]       dig_q, dig_prev_q;
    logic [7:0]       cnt_q, cnt_d;

    logic one_hot;
    logic multi;
    logic same;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q      <= '0;
            dig_q      <= '0;
            seg_prev_q <= '0;
            dig_prev_q <= '0;
            cnt_q      <= '0;
        end else begin
            seg_q      <= SEG_ACTIVE_LOW ? ~ssd : ssd;
            dig_q      <= DIG_ACTIVE_LOW ? ~dig : dig;
            seg_prev_q <= seg_q;
            dig_prev_q <= dig_q;
            cnt_q      <= cnt_d;
        end
    end

    assign multi   = (dig_q & (dig_q - 4'd1)) != 4'd0;
    assign one_hot = (dig_q != 4'd0) && !multi;
    assign same    = (seg_q == seg_prev_q) && (dig_q == dig_prev_q);

    always_comb begin
        cnt_d = cnt_q;
        if (!one_hot) begin
            cnt_d = 8'd0;
        end else if (!same) begin
            cnt_d = 8'd1;
        end else if (cnt_q < SettleMax) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Fires only on the transition into SettleMax, so holding a pattern
    // longer never recaptures it.
    assign capture = one_hot && (cnt_d == SettleMax) && (cnt_q != SettleMax);
    assign glitch  = multi;
    assign seg_cap = seg_q;
    assign dig_cap = dig_q;

endmodule

// File: rtl/ssd_scan_decoder.sv
// Receive-side decoder for a 4-digit multiplexed 7-segment display.
// Reconstructs the four displayed hex digits from the scanned bus. It flags
// blank and unrecognised glyphs per digit, and pulses frame_valid once every
// digit has been captured since the previous frame.
//
// Ports:
//   clk, rst_n     clock and synchronous active-low reset
//   ssd            segment bus, bit0=a .. bit6=g
//   dig            digit selects, dig[0] = rightmost digit
//   digits         live decoded values, digit i at [4i+3:4i]
//   blank          digit i last captured as all segments off
//   err            digit i last captured as an unrecognised pattern
//   frame          snapshot of digits at the last frame_valid
//   frame_valid    one-cycle pulse when a complete frame has been scanned
//   frame_changed  one-cycle pulse with frame_valid when the frame differs
//   glitch         one-cycle pulse per cycle with several selects active

module ssd_scan_decoder
    import ssd_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEG_W-1:0] ssd,
    input  logic [3:0]       dig,
    output logic [15:0]      digits,
    output logic [3:0]       blank,
    output logic [3:0]       err,
    output logic [15:0]      frame,
    output logic             frame_valid,
    output logic             frame_changed,
    output logic             glitch
);

    logic [SEG_W-1:0] seg_cap;
    logic [3:0]       dig_cap;
    logic             capture;

    ssd_settle_filter #(
        .SETTLE_CYCLES  (SETTLE_CYCLES),
        .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW),
        .DIG_ACTIVE_LOW (DIG_ACTIVE_LOW)
    ) u_settle (
        .clk     (clk),
        .rst_n   (rst_n),
        .ssd     (ssd),
        .dig     (dig),
        .seg_cap (seg_cap),
        .dig_cap (dig_cap),
        .capture (capture),
        .glitch  (glitch)
    );

    logic [15:0] digits_q, digits_d;
    logic [3:0]  blank_q, blank_d;
    logic [3:0]  err_q, err_d;
    logic [15:0] frame_q, frame_d;
    logic [3:0]  seen_q, seen_d;
    logic        first_q, first_d;   // no frame completed since reset
    logic        frame_valid_q, frame_valid_d;
    logic        frame_changed_q, frame_changed_d;

    seg_dec_t    dec;
    logic [1:0]  idx;

    assign dec = seg_decode(seg_cap);

    always_comb begin
        idx = 2'd0;
        unique case (dig_cap)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    always_comb begin
        digits_d        = digits_q;
        blank_d         = blank_q;
        err_d           = err_q;
        frame_d         = frame_q;
        seen_d          = seen_q;
        first_d         = first_q;
        frame_valid_d   = 1'b0;
        frame_changed_d = 1'b0;

        if (capture) begin
            if (dec.valid) begin
                digits_d[{idx, 2'b00} +: 4] = dec.value;
                blank_d[idx]                = 1'b0;
                err_d[idx]                  = 1'b0;
            end else if (dec.blank) begin
                blank_d[idx] = 1'b1;
                err_d[idx]   = 1'b0;
            end else begin
                blank_d[idx] = 1'b0;
                err_d[idx]   = 1'b1;
            end

            seen_d = seen_q | dig_cap;
            if (seen_d == 4'hF) begin
                frame_valid_d   = 1'b1;
                // Compare against the snapshot including this capture.
                frame_changed_d = first_q || (digits_d != frame_q);
                frame_d         = digits_d;
                seen_d          = 4'h0;
                first_d         = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digits_q        <= '0;
            blank_q         <= 4'hF;
            err_q           <= '0;
            frame_q         <= '0;
            seen_q          <= '0;
            first_q         <= 1'b1;
            frame_valid_q   <= 1'b0;
            frame_changed_q <= 1'b0;
        end else begin
            digits_q        <= digits_d;
            blank_q         <= blank_d;
            err_q           <= err_d;
            frame_q         <= frame_d;
            seen_q          <= seen_d;
            first_q         <= first_d;
            frame_valid_q   <= frame_valid_d;
            frame_changed_q <= frame_changed_d;
        end
    end

    assign digits        = digits_q;
    assign blank         = blank_q;
    assign err           = err_q;
    assign frame         = frame_q;
    assign frame_valid   = frame_valid_q;
    assign frame_changed = frame_changed_q;

endmodule

// File: doc/ssd_scan_decoder.md
Name: ssd_scan_decoder

Overview:
- Receive-side counterpart of the digital lock's display drive. Samples the multiplexed 7-segment bus (ssd, dig) and reconstructs the four displayed hex digits.
- Rejects ghosting at digit transitions with a settle filter.
- Flags blank and illegal patterns, and emits a pulse each time a complete four-digit frame has been scanned.
- Used as a checker or monitor next to tt_um_top, or on a second board reading the lock's display pins.

Parameters:
- SETTLE_CYCLES, 4, consecutive identical (dig, ssd) samples required before capture; legal range 2..255.
- SEG_ACTIVE_LOW, 1, 1 = ssd segments are active-low on the pins.
- DIG_ACTIVE_LOW, 1, 1 = dig selects are active-low on the pins.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- ssd  input  7  segment bus, bit0=a … bit6=g
- dig  input  4  digit selects, dig[0] = rightmost digit
- digits  output  16  live decoded values, digit i at [4i+3:4i]
- blank  output  4  digit i last captured as all-segments-off
- err  output  4  digit i last captured as an unrecognised pattern
- frame  output  16  snapshot of digits at the last frame_valid
- frame_valid  output  1  one-cycle pulse: all four digits captured since the previous frame
- frame_changed  output  1  one-cycle pulse coincident with frame_valid when the new frame differs from the previous one
- glitch  output  1  one-cycle pulse when the registered dig has more than one select active

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - digits=0, frame=0, blank=4'hF, err=0.
  - frame_valid, frame_changed and glitch are 0.
  - Settle counter, seen mask and input registers are cleared.
  - Reset mid-scan discards the partial frame. The first frame after reset always asserts frame_changed.
- Input stage:
  - ssd and dig are registered once.
  - The registered values are normalised to active-high by inverting per the SEG_ACTIVE_LOW and DIG_ACTIVE_LOW parameters.
- Settle counter (8-bit, saturating at SETTLE_CYCLES):
  - Registered pair equal to the previous registered pair: increment.
  - Pair differs: reload to 1.
  - Normalised dig not exactly one-hot (zero or multiple selects): counter held at 0 and no capture.
  - Multiple selects also raise glitch for one cycle per cycle the condition holds.
- Capture:
  - Occurs on the single cycle the counter reaches SETTLE_CYCLES with a one-hot dig.
  - Holding the same pattern longer does not recapture.
  - Latency: a stable input pattern is reflected on digits/blank/err SETTLE_CYCLES+1 clock edges after it first appears at the pins.
- Decode of normalised segments {g..a}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Legal pattern: digit value written, blank[i]=0, err[i]=0.
  - 00: blank[i]=1, err[i]=0, digit value unchanged.
  - Anything else: err[i]=1, blank[i]=0, digit value unchanged.
- Frame assembly:
  - The seen mask sets bit i on each capture of digit i.
  - On the capture that makes the mask 4'hF: frame_valid=1 for one cycle, frame <= digits (including this capture), and the mask clears to 0.
  - frame_changed=1 on that same cycle if the new frame differs from the old frame register or if this is the first frame since reset.
- Scan order: any order is accepted. Re-capturing an already-seen digit before the frame completes overwrites its value and does not advance the frame.
- Dead time: all selects off is treated as idle. It is not an error and does not clear the seen mask.

Decomposition:
- Shared package ssd_pkg holds:
  - segment-bit index constants (SEG_A..SEG_G);
  - the 16-entry hex→segment table and the SEG_BLANK constant;
  - a decode function returning {valid, blank, value[3:0]}.
- The lock's encoder uses the same table, so the two ends cannot drift apart.
- One sub-module: ssd_settle_filter (input registers, normalisation, counter, one-hot check, capture strobe, glitch).
- Decode and frame logic stay in the top.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles → digits=0000, blank=F, err=0, frame_valid=0 throughout.
- Settle and latency (active-low pins, SETTLE_CYCLES=4): drive dig=1110, ssd=~06 → digits[3:0]=1 on exactly the 5th edge; reapply the pattern after a 3-cycle hold → no capture.
- Full frame: scan 1,2,3,4 across dig[0..3] with 8-cycle dwell → one frame_valid pulse, frame=16'h4321, frame_changed=1. Identical second scan → frame_valid=1, frame_changed=0.
- Ghost rejection: on each digit transition insert 2 cycles of the old ssd with the new dig → digits unaffected; captured values match the settled patterns.
- Blank, error and glitch: ssd=~00 on dig[2] → blank[2]=1, digit value retained. ssd=~12 → err[2]=1. dig=1100 for one cycle → glitch pulses once, no capture.
- Mid-frame reset: capture digits 0 and 1, pulse rst_n low for one cycle, then capture digits 2 and 3 → no frame_valid until all four are recaptured.
